program_loader: RTL
===================

# program_loader

Byte-stream bootloader that sits directly upstream of the instruction/data memory and drives its write port. It receives a word count and a sequence of big-endian 32-bit instruction words over a valid/ready byte interface, then writes each word to consecutive memory addresses starting at a fixed base. It holds the processor in `busy` while loading and pulses `done` when the image is complete, so the core can be released from reset and fetch from address 0.

## Interface
Parameters:
- `DEPTH`, 128: memory depth in words; upper bound on the image.
- `BASE_ADDR`, 0: address of the first word written.

Ports:
- `clk`  in  1: single clock; memory write clock (`wclk`) is tied to this same clock.
- `reset`  in  1: asynchronous, active-high reset.
- `start`  in  1: one-cycle request to begin a load; ignored unless idle.
- `in_data`  in  8: stream byte.
- `in_valid`  in  1: `in_data` valid.
- `in_ready`  out  1: loader accepts a byte this cycle.
- `mem_data`  out  32: word to memory `dado`.
- `mem_addr`  out  10: address to memory `endereco`.
- `mem_write`  out  1: memory `write` strobe, one cycle per word.
- `busy`  out  1: load in progress; holds the core.
- `done`  out  1: one-cycle pulse on successful completion.
- `error`  out  1: sticky fault flag; cleared by the next accepted `start`.

## Operation
- States: IDLE, HDR_HI, HDR_LO, WORD, WRITE, CHECK (macro only), FINISH.
- IDLE: `in_ready`=0, `busy`=0. `start`=1 clears `error`, clears word index and byte counter, moves to HDR_HI.
- Byte transfer happens only on a cycle where `in_valid` and `in_ready` are both high.
- HDR_HI / HDR_LO: the first two bytes form the 16-bit word count N, high byte first. When the low byte is accepted, the count is checked:
  - N=0 or N > DEPTH-BASE_ADDR: `error`=1, go to IDLE with nothing written.
  - Otherwise go to WORD.
- WORD: accepts 4 bytes big-endian into `mem_data`. The first byte goes to [31:24] and the last to [7:0]. After the 4th byte go to WRITE.
- WRITE: `mem_write`=1 and `in_ready`=0 for exactly one cycle. `mem_addr` = BASE_ADDR + index.
  - Index < N-1: increment the index, return to WORD.
  - Last word: go to CHECK (macro defined) or FINISH.
- FINISH: `done`=1 for one cycle, then IDLE.
- `busy`=1 in every state except IDLE.
- `start` while not in IDLE is ignored.
- `in_data` is ignored whenever `in_ready`=0.
- Address arithmetic: 10-bit. BASE_ADDR + N ≤ DEPTH guarantees no wrap.

## Timing
- Reset values: state IDLE; `in_ready`, `mem_write`, `busy`, `done`, `error` = 0; `mem_data`=0; `mem_addr`=BASE_ADDR.
- `start` accepted in cycle t gives `busy`=1 and `in_ready`=1 at t+1.
- `mem_data` and `mem_addr` are registered and stable during the WRITE cycle. The memory captures on the rising edge ending that cycle.
- Throughput: 5 cycles per word minimum (4 byte accepts + 1 WRITE).
- `done` is asserted the cycle after the last WRITE (or after CHECK). `busy` falls in the cycle after `done`.
- Reset asserted mid-load: immediate return to IDLE with all outputs at reset values. Words already written stay in memory; the partial word is discarded.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - After the last WRITE, state CHECK accepts one extra byte with `in_ready`=1.
  - The byte must equal the XOR of all 4N data bytes (header excluded).
  - Match: go to FINISH.
  - Mismatch: `error`=1, no `done`, return to IDLE. Memory remains written.
- Not defined: no CHECK state, no checksum byte, and FINISH follows the last WRITE directly.

## Test plan
- Reset, then idle 10 cycles -> all outputs 0, `mem_addr`=0, `in_ready`=0, and `in_valid` bytes are ignored.
- `start`, then bytes 00 02, 04 00 01 CD, 54 00 00 1B -> writes 0x040001CD @0 and 0x5400001B @1. `done` pulses once, `busy` falls, `error`=0.
- Same stream with `in_valid` toggled every other cycle -> identical writes. `mem_write` is never asserted while bytes are outstanding.
- Header 00 81 with DEPTH=128 -> `error`=1, no `mem_write`, back to IDLE. A following `start` clears `error`.
- `reset` pulsed after 2 of 3 words -> words 0–1 written, no third write, no `done`, outputs at reset values.
- With `LOADER_CHECKSUM_EN`: one word 12 34 56 78 plus checksum 08 -> `done`. With checksum 09 -> `error`=1, no `done`.

Source files
------------

// File: rtl/program_loader.sv
// rtl/program_loader.sv - byte-stream bootloader driving the instruction/data memory write port
//
// Receives a 16-bit word count (high byte first) followed by N big-endian
// 32-bit words over a valid/ready byte stream, and writes them to consecutive
// memory addresses starting at BASE_ADDR. Holds the core in busy while loading.
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   When defined, one extra byte follows the last word and must equal the XOR
//   of all 4N data bytes; a mismatch raises error instead of done.
//
// Parameters:
//   DEPTH      memory depth in words (upper bound on the image)
//   BASE_ADDR  address of the first word written
//
// Ports:
//   clk        in   1   clock (memory write clock is the same clock)
//   reset      in   1   asynchronous active-high reset
//   start      in   1   one-cycle load request, honoured only when idle
//   in_data    in   8   stream byte
//   in_valid   in   1   in_data valid
//   in_ready   out  1   loader accepts a byte this cycle
//   mem_data   out  32  word to memory
//   mem_addr   out  10  memory address
//   mem_write  out  1   memory write strobe, one cycle per word
//   busy       out  1   load in progress
//   done       out  1   one-cycle pulse on successful completion
//   error      out  1   sticky fault flag, cleared by the next accepted start

module program_loader #(
  parameter int DEPTH     = 128,
  parameter int BASE_ADDR = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] mem_data,
  output logic [9:0]  mem_addr,
  output logic        mem_write,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR_HI, S_HDR_LO, S_WORD, S_WRITE, S_CHECK, S_FINISH
  } state_t;

  localparam logic [9:0]  BASE  = 10'(BASE_ADDR);
  localparam logic [16:0] MAX_N = 17'(DEPTH - BASE_ADDR);

  state_t      state_q, state_d;
  logic [7:0]  cnt_hi_q;
  logic [15:0] n_q;
  logic [15:0] idx_q;
  logic [1:0]  byte_cnt_q;
  logic [31:0] mem_data_q;
  logic [9:0]  mem_addr_q;
  logic        error_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum_q;
`endif

  logic        accept;
  logic [15:0] hdr_n;
  logic        hdr_bad;
  logic        last_word;

  assign accept    = in_valid & in_ready;
  assign hdr_n     = {cnt_hi_q, in_data};
  // Widened compare so a count of 0xFFFF cannot alias into range.
  assign hdr_bad   = (hdr_n == 16'd0) || ({1'b0, hdr_n} > MAX_N);
  assign last_word = (idx_q == n_q - 16'd1);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_HDR_HI;
      S_HDR_HI: if (accept) state_d = S_HDR_LO;
      S_HDR_LO: if (accept) state_d = hdr_bad ? S_IDLE : S_WORD;
      S_WORD:   if (accept && byte_cnt_q == 2'd3) state_d = S_WRITE;
      S_WRITE: begin
        if (!last_word) state_d = S_WORD;
`ifdef LOADER_CHECKSUM_EN
        else            state_d = S_CHECK;
`else
        else            state_d = S_FINISH;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK:  if (accept) state_d = (in_data == csum_q) ? S_FINISH : S_IDLE;
`endif
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output decode (pure function of state)
  always_comb begin
    in_ready  = 1'b0;
    mem_write = 1'b0;
    done      = 1'b0;
    busy      = (state_q != S_IDLE);
    case (state_q)
      S_HDR_HI, S_HDR_LO, S_WORD: in_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_CHECK:  in_ready = 1'b1;
`endif
      S_WRITE:  mem_write = 1'b1;
      S_FINISH: done = 1'b1;
      default:  ;
    endcase
  end

  // Datapath: header, word assembly, index/address and error flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_hi_q   <= 8'd0;
      n_q        <= 16'd0;
      idx_q      <= 16'd0;
      byte_cnt_q <= 2'd0;
      mem_data_q <= 32'd0;
      mem_addr_q <= BASE;
      error_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= 8'd0;
`endif
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          error_q    <= 1'b0;
          idx_q      <= 16'd0;
          byte_cnt_q <= 2'd0;
          mem_addr_q <= BASE;
`ifdef LOADER_CHECKSUM_EN
          csum_q     <= 8'd0;
`endif
        end
        S_HDR_HI: if (accept) cnt_hi_q <= in_data;
        S_HDR_LO: if (accept) begin
          n_q <= hdr_n;
          if (hdr_bad) error_q <= 1'b1;
        end
        S_WORD: if (accept) begin
          // Shifting left lands the first byte in [31:24] after four accepts;
          // the 2-bit counter wraps back to 0 ready for the next word.
          mem_data_q <= {mem_data_q[23:0], in_data};
          byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          csum_q     <= csum_q ^ in_data;
`endif
        end
        S_WRITE: if (!last_word) begin
          idx_q      <= idx_q + 16'd1;
          mem_addr_q <= mem_addr_q + 10'd1;
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHECK: if (accept && in_data != csum_q) error_q <= 1'b1;
`endif
        default: ;
      endcase
    end
  end

  assign mem_data = mem_data_q;
  assign mem_addr = mem_addr_q;
  assign error    = error_q;

endmodule
